// File: rtl/spi_txn_sequencer_pkg.sv
// Shared definitions for the SPI transaction sequencer: FSM state encoding and
// the slave-select index width helper.
package spi_txn_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_ABORT     = 3'd4,
    ST_DRAIN     = 3'd5
  } state_e;

  // Index width for a slave count; never narrower than one bit.
  function automatic int sel_width(input int num_slaves);
    return (num_slaves <= 2) ? 1 : $clog2(num_slaves);
  endfunction

endpackage

// File: rtl/spi_txn_sequencer_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output. A push into a
// full FIFO is accepted only when a pop happens in the same cycle.
module spi_txn_sequencer_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q, level_d;
  logic             full, do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full    = (level_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Present zeros while empty so the consumer never sees a stale word.
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/spi_txn_sequencer.sv
// Command-queue front end for an SPI master: buffers commands, issues them one at
// a time with per-command slave select, collects read data and watchdog aborts.
module spi_txn_sequencer
  import spi_txn_sequencer_pkg::*;
#(
  parameter int  DATA_WIDTH     = 16,
  parameter int  NUM_SLAVES     = 2,
  parameter int  CMD_DEPTH      = 16,
  parameter int  RSP_DEPTH      = 16,
  parameter int  TIMEOUT_CYCLES = 1024,
  localparam int SEL_W          = sel_width(NUM_SLAVES),
  localparam int CLVL_W         = $clog2(CMD_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_read,
  input  logic [SEL_W-1:0]      cmd_slave,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [SEL_W-1:0]      rsp_slave,
  output logic                  rsp_timeout,
  output logic                  m_start_tx,
  output logic [DATA_WIDTH-1:0] m_tx_data,
  output logic [NUM_SLAVES-1:0] m_slave_sel,
  input  logic                  m_busy,
  input  logic                  m_irq,
  input  logic [DATA_WIDTH-1:0] m_rx_data,
  output logic [CLVL_W-1:0]     cmd_level,
  output logic                  err_timeout
);

  localparam int ENT_W  = 1 + SEL_W + DATA_WIDTH;
  localparam int RLVL_W = $clog2(RSP_DEPTH) + 1;
  localparam int WD_W   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RLVL_W-1:0] RSP_FULL = RLVL_W'(RSP_DEPTH);
  localparam logic [CLVL_W-1:0] CMD_FULL = CLVL_W'(CMD_DEPTH);

  function automatic logic [NUM_SLAVES-1:0] slave_onehot(input logic [SEL_W-1:0] s);
    logic [NUM_SLAVES-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_SLAVES; i++) oh[i] = (s == SEL_W'(i));
    return oh;
  endfunction

  logic [ENT_W-1:0]      cmd_dout, rsp_din, rsp_dout;
  logic                  cmd_empty, cmd_push, cmd_pop, rsp_empty, rsp_push, rsp_room;
  logic [RLVL_W-1:0]     rsp_level;
  logic                  head_read;
  logic [SEL_W-1:0]      head_slave;
  logic [DATA_WIDTH-1:0] head_data;

  state_e                state_q, state_d;
  logic                  start_q, start_d, err_q, err_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic [DATA_WIDTH-1:0] txd_q, txd_d, rx_q, rx_d;
  logic                  cur_read_q, cur_read_d;
  logic [SEL_W-1:0]      cur_slave_q, cur_slave_d;
  logic [WD_W-1:0]       wd_q, wd_d;

  assign cmd_ready = (cmd_level != CMD_FULL);
  assign cmd_push  = cmd_valid && cmd_ready;
  assign rsp_room  = (rsp_level != RSP_FULL);

  assign head_read  = cmd_dout[ENT_W-1];
  assign head_slave = cmd_dout[DATA_WIDTH +: SEL_W];
  assign head_data  = cmd_dout[DATA_WIDTH-1:0];

  spi_txn_sequencer_sync_fifo #(.WIDTH(ENT_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_push),
    .din_i   ({cmd_read, cmd_slave, cmd_data}),
    .pop_i   (cmd_pop),
    .dout_o  (cmd_dout),
    .empty_o (cmd_empty),
    .level_o (cmd_level)
  );

  spi_txn_sequencer_sync_fifo #(.WIDTH(ENT_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rsp_push),
    .din_i   (rsp_din),
    .pop_i   (rsp_ready),
    .dout_o  (rsp_dout),
    .empty_o (rsp_empty),
    .level_o (rsp_level)
  );

  always_comb begin
    state_d     = state_q;
    start_d     = 1'b0;
    sel_d       = sel_q;
    txd_d       = txd_q;
    err_d       = err_q;
    cur_read_d  = cur_read_q;
    cur_slave_d = cur_slave_q;
    rx_d        = rx_q;
    wd_d        = wd_q;
    cmd_pop     = 1'b0;
    rsp_push    = 1'b0;
    rsp_din     = {1'b0, cur_slave_q, rx_q};
    case (state_q)
      ST_IDLE: begin
        // A read may only launch once its response is guaranteed a slot.
        if (!cmd_empty && (!head_read || rsp_room) && !m_busy) begin
          cmd_pop     = 1'b1;
          cur_read_d  = head_read;
          cur_slave_d = head_slave;
          start_d     = 1'b1;
          sel_d       = slave_onehot(head_slave);
          txd_d       = head_data;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wd_d    = '0;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (m_irq) begin
          rx_d    = m_rx_data;
          state_d = ST_CAPTURE;
        end else if (wd_q == WD_LAST) begin
          state_d = ST_ABORT;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      ST_CAPTURE: begin
        rsp_push = cur_read_q;
        sel_d    = '0;
        state_d  = ST_IDLE;
      end
      ST_ABORT: begin
        rsp_push = 1'b1;
        rsp_din  = {1'b1, cur_slave_q, {DATA_WIDTH{1'b0}}};
        err_d    = 1'b1;
        sel_d    = '0;
        state_d  = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!m_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      sel_q   <= '0;
      txd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      sel_q   <= sel_d;
      txd_q   <= txd_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    cur_read_q  <= cur_read_d;
    cur_slave_q <= cur_slave_d;
    rx_q        <= rx_d;
    wd_q        <= wd_d;
  end

  assign m_start_tx  = start_q;
  assign m_slave_sel = sel_q;
  assign m_tx_data   = txd_q;
  assign err_timeout = err_q;
  assign rsp_valid   = !rsp_empty;
  assign rsp_timeout = rsp_dout[ENT_W-1];
  assign rsp_slave   = rsp_dout[DATA_WIDTH +: SEL_W];
  assign rsp_data    = rsp_dout[DATA_WIDTH-1:0];

endmodule
